meduram_rdagent: RTL and testbench
==================================

MEDURAM_RDAGENT -- requirements
Module: meduram_rdagent

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 3, read address width.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 8, read data width.
REQ-003 The block SHALL have parameter AGENT_ID, default 1, RAM read port served (1 or 2); read-collision loser when 2.
REQ-004 The block SHALL have parameter MAX_RETRY, default 3, re-issues allowed after a lost read collision.
REQ-005 Port: aclk, in, 1, single clock; all logic on its rising edge.
REQ-006 Port: aresetn, in, 1, asynchronous active-low reset.
REQ-007 Port: req_valid, in, 1, client read request valid.
REQ-008 Port: req_ready, out, 1, block accepts request.
REQ-009 Port: req_addr, in, ADDR_WIDTH, client read address.
REQ-010 Port: rsp_valid, out, 1, response valid.
REQ-011 Port: rsp_ready, in, 1, client accepts response.
REQ-012 Port: rsp_data, out, DATA_WIDTH, read data.
REQ-013 Port: rsp_status, out, 2, 0=OK, 1=write-collision flagged, 2=retries exhausted.
REQ-014 Port: rden, out, 1, RAM read enable for this agent's port.
REQ-015 Port: rdaddr, out, ADDR_WIDTH, RAM read address.
REQ-016 Port: rddata, in, DATA_WIDTH, RAM read data, valid one cycle after rden.
REQ-017 Port: rdcollision, in, 2, RAM collision code sampled with rddata: 0 none, 1 write collision, 2 read collision.

Function
REQ-018 The block SHALL implement FSM states IDLE, ISSUE, WAIT, RESP.
REQ-019 IDLE: req_ready=1; on req_valid&req_ready, the block SHALL latch req_addr, clear retry count, go to ISSUE.
REQ-020 ISSUE: rden=1 and rdaddr=latched address for exactly one cycle, then WAIT.
REQ-021 WAIT: rden=0; the block SHALL sample rddata and rdcollision on the edge ending WAIT.
REQ-022 If rdcollision==2 and AGENT_ID==2 and retry count<MAX_RETRY, the block SHALL increment the count and return to ISSUE (data discarded).
REQ-023 If rdcollision==2 and AGENT_ID==2 and retry count==MAX_RETRY, the block SHALL go to RESP with rsp_status=2 and rsp_data=0.
REQ-024 If rdcollision==2 and AGENT_ID==1, the block SHALL treat data as valid, status 0.
REQ-025 If rdcollision==1, the block SHALL go to RESP with captured data and rsp_status=1.
REQ-026 If rdcollision==0, the block SHALL go to RESP with captured data and rsp_status=0.
REQ-027 RESP: rsp_valid=1 and rsp_data/rsp_status SHALL stay stable until rsp_ready; on rsp_valid&rsp_ready, return to IDLE.
REQ-028 Only one request SHALL be outstanding; req_ready=0 in ISSUE, WAIT, RESP.
REQ-029 Minimum latency, accept to rsp_valid, SHALL be 3 cycles; each retry SHALL add 2.
REQ-030 Retry counter SHALL be $clog2(MAX_RETRY+1) bits and SHALL not wrap.
REQ-031 rdaddr SHALL hold its last value when rden=0.

Reset
REQ-032 On aresetn low, the block SHALL enter IDLE asynchronously, with req_ready=1 after release.
REQ-033 Under reset, rden=0, rdaddr=0, rsp_valid=0, rsp_data=0, rsp_status=0, and retry count=0.
REQ-034 Reset mid-operation SHALL abandon the request without a response.

Structure
REQ-035 A shared package meduram_pkg SHALL hold the collision codes (COLL_NONE=0, COLL_WRITE=1, COLL_READ=2), rsp_status codes, and the FSM state enum.
REQ-036 The block SHALL be a single module with no sub-module.

Verification
REQ-037 AGENT_ID=2: request addr 5, RAM returns 0xA5 with code 0 -> rden pulse 1 cycle later; rsp_valid 3 cycles after accept, data 0xA5, status 0.
REQ-038 AGENT_ID=2: code 2 twice then 0 with 0x3C -> 3 rden pulses, 2 cycles apart; response 0x3C, status 0, at latency 7.
REQ-039 AGENT_ID=2, MAX_RETRY=3: code 2 always -> 4 rden pulses; response status 2, data 0.
REQ-040 AGENT_ID=1: code 2 with 0x77 -> single rden; response 0x77, status 0.
REQ-041 Code 1 with 0x11, rsp_ready held low 5 cycles -> rsp_valid, data 0x11, and status 1 stable throughout; req_ready=0 until the handshake.
REQ-042 aresetn low during WAIT -> rden=0 and rsp_valid=0 immediately; req_ready=1 after release; no response issued.

Source files
------------

// File: rtl/meduram_pkg.sv
// Shared definitions for the meduram read agent: RAM collision codes,
// response status codes and the agent FSM state encoding.
package meduram_pkg;

    typedef enum logic [1:0] {
        COLL_NONE  = 2'd0,
        COLL_WRITE = 2'd1,
        COLL_READ  = 2'd2
    } coll_e;

    typedef enum logic [1:0] {
        RSP_OK        = 2'd0,
        RSP_WCOLL     = 2'd1,
        RSP_EXHAUSTED = 2'd2
    } rsp_status_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

endpackage

// File: rtl/meduram_rdagent_if.sv
// Client request/response handshake plus the RAM read port of one agent.
// The agent uses the slave modport; the client/RAM side uses master.
interface meduram_rdagent_if #(
    parameter int ADDR_WIDTH = 3,
    parameter int DATA_WIDTH = 8
);
    logic                  req_valid;
    logic                  req_ready;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_data;
    logic [1:0]            rsp_status;
    logic                  rden;
    logic [ADDR_WIDTH-1:0] rdaddr;
    logic [DATA_WIDTH-1:0] rddata;
    logic [1:0]            rdcollision;

    modport slave (
        input  req_valid, req_addr, rsp_ready, rddata, rdcollision,
        output req_ready, rsp_valid, rsp_data, rsp_status, rden, rdaddr
    );

    modport master (
        output req_valid, req_addr, rsp_ready, rddata, rdcollision,
        input  req_ready, rsp_valid, rsp_data, rsp_status, rden, rdaddr
    );
endinterface

// File: rtl/meduram_rdagent.sv
// Single-outstanding RAM read agent: issues one read per request and, as the
// losing port (AGENT_ID 2), re-issues on read collisions up to MAX_RETRY times.
module meduram_rdagent
    import meduram_pkg::*;
#(
    parameter int ADDR_WIDTH = 3,
    parameter int DATA_WIDTH = 8,
    parameter int AGENT_ID   = 1,
    parameter int MAX_RETRY  = 3
) (
    input  logic               aclk,
    input  logic               aresetn,
    meduram_rdagent_if.slave   bus
);

    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [RW-1:0] RETRY_LIMIT = RW'(MAX_RETRY);
    localparam bit IS_LOSER = (AGENT_ID == 2);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [RW-1:0]         retryCnt_q, retryCnt_d;
    logic [DATA_WIDTH-1:0] rspData_q, rspData_d;
    logic [1:0]            rspStatus_q, rspStatus_d;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            retryCnt_q  <= '0;
            rspData_q   <= '0;
            rspStatus_q <= RSP_OK;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            retryCnt_q  <= retryCnt_d;
            rspData_q   <= rspData_d;
            rspStatus_q <= rspStatus_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        retryCnt_d  = retryCnt_q;
        rspData_d   = rspData_q;
        rspStatus_d = rspStatus_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    addr_d     = bus.req_addr;
                    retryCnt_d = '0;
                    state_d    = ST_ISSUE;
                end
            end
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT: begin
                // Only the losing port sees a read collision as corrupted data.
                if (IS_LOSER && bus.rdcollision == COLL_READ) begin
                    if (retryCnt_q < RETRY_LIMIT) begin
                        retryCnt_d = retryCnt_q + RW'(1);
                        state_d    = ST_ISSUE;
                    end else begin
                        rspData_d   = '0;
                        rspStatus_d = RSP_EXHAUSTED;
                        state_d     = ST_RESP;
                    end
                end else begin
                    rspData_d   = bus.rddata;
                    rspStatus_d = (bus.rdcollision == COLL_WRITE) ? RSP_WCOLL : RSP_OK;
                    state_d     = ST_RESP;
                end
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // addr_q only changes on acceptance, so rdaddr holds between issues.
    assign bus.req_ready  = (state_q == ST_IDLE);
    assign bus.rden       = (state_q == ST_ISSUE);
    assign bus.rdaddr     = addr_q;
    assign bus.rsp_valid  = (state_q == ST_RESP);
    assign bus.rsp_data   = rspData_q;
    assign bus.rsp_status = rspStatus_q;

endmodule

// File: tb/tb_meduram_rdagent.sv
// Self-checking bench: one agent of each AGENT_ID shares a scripted RAM model;
// a queue-driven reference model predicts pulses, latency, data and status.
module tb_meduram_rdagent;

    localparam int AW = 3;
    localparam int DW = 8;
    localparam int MAX_RETRY = 3;

    logic aclk;
    logic aresetn;

    meduram_rdagent_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) ifA1 ();
    meduram_rdagent_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) ifA2 ();

    meduram_rdagent #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .AGENT_ID(1), .MAX_RETRY(MAX_RETRY))
        dutA1 (.aclk(aclk), .aresetn(aresetn), .bus(ifA1.slave));
    meduram_rdagent #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .AGENT_ID(2), .MAX_RETRY(MAX_RETRY))
        dutA2 (.aclk(aclk), .aresetn(aresetn), .bus(ifA2.slave));

    bit              sel2;
    logic            reqValid;
    logic [AW-1:0]   reqAddr;
    logic            rspReady;
    logic [DW-1:0]   ramData;
    logic [1:0]      ramColl;
    int              collPlan[$];
    int              dataPlan[$];
    int              numCompared;
    int              numMismatched;

    logic            curReqReady, curRspValid, curRden;
    logic [AW-1:0]   curRdaddr;
    logic [DW-1:0]   curRspData;
    logic [1:0]      curRspStatus;

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    assign ifA1.req_valid   = reqValid & ~sel2;
    assign ifA2.req_valid   = reqValid & sel2;
    assign ifA1.req_addr    = reqAddr;
    assign ifA2.req_addr    = reqAddr;
    assign ifA1.rsp_ready   = rspReady & ~sel2;
    assign ifA2.rsp_ready   = rspReady & sel2;
    assign ifA1.rddata      = ramData;
    assign ifA2.rddata      = ramData;
    assign ifA1.rdcollision = ramColl;
    assign ifA2.rdcollision = ramColl;

    assign curReqReady  = sel2 ? ifA2.req_ready  : ifA1.req_ready;
    assign curRspValid  = sel2 ? ifA2.rsp_valid  : ifA1.rsp_valid;
    assign curRden      = sel2 ? ifA2.rden       : ifA1.rden;
    assign curRdaddr    = sel2 ? ifA2.rdaddr     : ifA1.rdaddr;
    assign curRspData   = sel2 ? ifA2.rsp_data   : ifA1.rsp_data;
    assign curRspStatus = sel2 ? ifA2.rsp_status : ifA1.rsp_status;

    // Scripted RAM: each read pops the next planned data/collision pair,
    // falling back to data 0 with no collision once the script runs out.
    always @(posedge aclk) begin
        if (curRden) begin
            ramData <= (dataPlan.size() > 0) ? DW'(dataPlan.pop_front()) : '0;
            ramColl <= (collPlan.size() > 0) ? 2'(collPlan.pop_front()) : 2'd0;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        numCompared++;
        if (observed !== expected) begin
            numMismatched++;
            $display("[TB] FAIL %s: observed %0h, expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic applyStimulus(input bit useAgent2, input logic [AW-1:0] addr, input int holdCycles);
        int codes[$];
        int datas[$];
        int expAttempts, expStatus, expLat, pulses, lat, code, dat;
        logic [DW-1:0] expData;
        codes = collPlan;
        datas = dataPlan;
        expAttempts = 0;
        expStatus = 0;
        expData = '0;
        for (int a = 0; a < 32; a++) begin
            code = (a < codes.size()) ? codes[a] : 0;
            dat  = (a < datas.size()) ? datas[a] : 0;
            expAttempts = a + 1;
            if (code == 2 && useAgent2) begin
                if (a < MAX_RETRY) continue;
                expStatus = 2;
                expData = '0;
                break;
            end
            expData = DW'(dat);
            expStatus = (code == 1) ? 1 : 0;
            break;
        end
        expLat = 2 * expAttempts + 1;

        sel2 = useAgent2;
        reqAddr = addr;
        reqValid = 1'b1;
        #1;
        checkOutput("req_ready_idle", 32'(curReqReady), 32'd1);
        @(posedge aclk);
        #1 reqValid = 1'b0;
        pulses = 0;
        lat = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge aclk);
            if (curRden) begin
                pulses++;
                checkOutput("rdaddr", 32'(curRdaddr), 32'(addr));
            end
            if (curRspValid) begin
                lat = k;
                break;
            end
            checkOutput("req_ready_busy", 32'(curReqReady), 32'd0);
        end
        checkOutput("latency", 32'(lat), 32'(expLat));
        checkOutput("rden_pulses", 32'(pulses), 32'(expAttempts));
        checkOutput("rsp_data", 32'(curRspData), 32'(expData));
        checkOutput("rsp_status", 32'(curRspStatus), 32'(expStatus));
        repeat (holdCycles) begin
            @(negedge aclk);
            checkOutput("hold_rsp_valid", 32'(curRspValid), 32'd1);
            checkOutput("hold_rsp_data", 32'(curRspData), 32'(expData));
            checkOutput("hold_rsp_status", 32'(curRspStatus), 32'(expStatus));
            checkOutput("hold_req_ready", 32'(curReqReady), 32'd0);
        end
        rspReady = 1'b1;
        @(posedge aclk);
        #1 rspReady = 1'b0;
        @(negedge aclk);
        checkOutput("post_rsp_valid", 32'(curRspValid), 32'd0);
        checkOutput("post_req_ready", 32'(curReqReady), 32'd1);
        collPlan.delete();
        dataPlan.delete();
    endtask

    initial begin
        numCompared = 0;
        numMismatched = 0;
        sel2 = 1'b1;
        reqValid = 1'b0;
        reqAddr = '0;
        rspReady = 1'b0;
        ramData = '0;
        ramColl = '0;
        aresetn = 1'b0;

        repeat (3) @(negedge aclk);
        checkOutput("reset_rden", 32'(ifA2.rden), 32'd0);
        checkOutput("reset_rdaddr", 32'(ifA2.rdaddr), 32'd0);
        checkOutput("reset_rsp_valid", 32'(ifA2.rsp_valid), 32'd0);
        checkOutput("reset_rsp_data", 32'(ifA2.rsp_data), 32'd0);
        checkOutput("reset_rsp_status", 32'(ifA2.rsp_status), 32'd0);
        checkOutput("reset_a1_rsp_valid", 32'(ifA1.rsp_valid), 32'd0);
        aresetn = 1'b1;
        @(negedge aclk);
        checkOutput("reset_req_ready", 32'(ifA2.req_ready), 32'd1);

        // Directed scenarios from the agent's intended behaviour.
        collPlan = '{0};       dataPlan = '{8'hA5};
        applyStimulus(1'b1, 3'd5, 0);
        collPlan = '{2, 2, 0}; dataPlan = '{8'h01, 8'h02, 8'h3C};
        applyStimulus(1'b1, 3'd2, 1);
        collPlan = '{2, 2, 2, 2, 2}; dataPlan = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50};
        applyStimulus(1'b1, 3'd7, 0);
        collPlan = '{2};       dataPlan = '{8'h77};
        applyStimulus(1'b0, 3'd1, 0);
        collPlan = '{1};       dataPlan = '{8'h11};
        applyStimulus(1'b1, 3'd4, 5);
        collPlan = '{1};       dataPlan = '{8'h22};
        applyStimulus(1'b0, 3'd6, 2);

        // Reset asserted while the agent is waiting on RAM data.
        sel2 = 1'b1;
        collPlan = '{0};       dataPlan = '{8'h5A};
        reqAddr = 3'd3;
        reqValid = 1'b1;
        @(posedge aclk);
        #1 reqValid = 1'b0;
        repeat (2) @(negedge aclk);
        aresetn = 1'b0;
        #1;
        checkOutput("mid_reset_rden", 32'(ifA2.rden), 32'd0);
        checkOutput("mid_reset_rsp_valid", 32'(ifA2.rsp_valid), 32'd0);
        @(negedge aclk);
        aresetn = 1'b1;
        #1;
        checkOutput("mid_reset_req_ready", 32'(ifA2.req_ready), 32'd1);
        repeat (6) begin
            @(negedge aclk);
            checkOutput("abandon_rsp_valid", 32'(ifA2.rsp_valid), 32'd0);
            checkOutput("abandon_rden", 32'(ifA2.rden), 32'd0);
        end
        collPlan.delete();
        dataPlan.delete();

        // Randomized traffic across both agents.
        for (int t = 0; t < 40; t++) begin
            int n;
            n = $urandom_range(1, 5);
            for (int j = 0; j < n; j++) begin
                collPlan.push_back($urandom_range(0, 2));
                dataPlan.push_back($urandom_range(0, 255));
            end
            applyStimulus(1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), $urandom_range(0, 3));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
        $finish;
    end

endmodule
